// File: rtl/pc_select_pipe_if.sv
// rtl/pc_select_pipe_if.sv - fetch-PC select bus between pipeline control and pc_select_pipe
interface pc_select_pipe_if #(
  parameter int ADDR_W    = 64,
  parameter int RAS_DEPTH = 8
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              stall;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valc;
  logic [ADDR_W-1:0] f_valp;
  logic [3:0]        m_icode;
  logic              m_cnd;
  logic [ADDR_W-1:0] m_vala;
  logic [3:0]        w_icode;
  logic [ADDR_W-1:0] w_valm;
  logic [ADDR_W-1:0] w_predpc;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] f_predpc;
  logic [1:0]        pc_src;
  logic              halted;
  logic [CNT_W-1:0]  ras_count;

  modport master (
    output stall, f_icode, f_valc, f_valp, m_icode, m_cnd, m_vala,
           w_icode, w_valm, w_predpc,
    input  pc, f_predpc, pc_src, halted, ras_count
  );

  modport slave (
    input  stall, f_icode, f_valc, f_valp, m_icode, m_cnd, m_vala,
           w_icode, w_valm, w_predpc,
    output pc, f_predpc, pc_src, halted, ras_count
  );
endinterface

// File: rtl/pc_select_pipe.sv
// rtl/pc_select_pipe.sv - Y86-64 fetch PC select and next-PC prediction
// Optional return-address stack enabled by defining PC_SELECT_RAS_EN.
module pc_select_pipe #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  pc_select_pipe_if.slave  bus
);
  localparam int         CNT_W      = $clog2(RAS_DEPTH) + 1;
  localparam logic [3:0] ICODE_HALT = 4'd0;
  localparam logic [3:0] ICODE_JXX  = 4'd7;
  localparam logic [3:0] ICODE_CALL = 4'd8;
  localparam logic [3:0] ICODE_RET  = 4'd9;

  logic [ADDR_W-1:0] pred_q;
  logic              halted_q;
  logic              upd_en;
  logic              mispredict;
  logic              ret_redirect;
  logic              ras_hit;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] f_predpc_c;

  assign upd_en     = !bus.stall && !halted_q;
  assign mispredict = (bus.m_icode == ICODE_JXX) && !bus.m_cnd;

`ifdef PC_SELECT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;
  logic [PTR_W-1:0]  ras_top_idx;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_upd;
  logic              ras_push;
  logic              ras_pop;

  // A correctly predicted ret needs no redirect; only a wrong RAS guess does.
  assign ret_redirect = (bus.w_icode == ICODE_RET) && (bus.w_valm != bus.w_predpc);

  assign ras_upd     = upd_en && !mispredict && !ret_redirect;
  assign ras_push    = ras_upd && (bus.f_icode == ICODE_CALL);
  assign ras_pop     = ras_upd && (bus.f_icode == ICODE_RET) && (ras_cnt != '0);
  assign ras_top_idx = ras_ptr - PTR_W'(1);
  assign ras_top     = ras_mem[ras_top_idx];
  assign ras_hit     = (ras_cnt != '0);

  // ras_ptr is the next free slot; wrapping lets a push on a full stack replace the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      if (ras_cnt != CNT_W'(RAS_DEPTH)) begin
        ras_cnt <= ras_cnt + CNT_W'(1);
      end
    end else if (ras_pop) begin
      ras_ptr <= ras_ptr - PTR_W'(1);
      ras_cnt <= ras_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) begin
      ras_mem[ras_ptr] <= bus.f_valp;
    end
  end

  assign bus.ras_count = ras_cnt;
`else
  logic unused_predpc;

  // Without a RAS every ret in W redirects; pipeline control stalls fetch behind it.
  assign ret_redirect  = (bus.w_icode == ICODE_RET);
  assign ras_hit       = 1'b0;
  assign ras_top       = bus.f_valp;
  assign unused_predpc = ^bus.w_predpc;
  assign bus.ras_count = '0;
`endif

  always_comb begin
    bus.pc     = pred_q;
    bus.pc_src = 2'd0;
    if (mispredict) begin
      bus.pc     = bus.m_vala;
      bus.pc_src = 2'd1;
    end else if (ret_redirect) begin
      bus.pc     = bus.w_valm;
      bus.pc_src = 2'd2;
    end
  end

  always_comb begin
    f_predpc_c = bus.f_valp;
    if ((bus.f_icode == ICODE_JXX) || (bus.f_icode == ICODE_CALL)) begin
      f_predpc_c = bus.f_valc;
    end else if ((bus.f_icode == ICODE_RET) && ras_hit) begin
      f_predpc_c = ras_top;
    end
  end

  assign bus.f_predpc = f_predpc_c;
  assign bus.halted   = halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_q   <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      if (upd_en) begin
        pred_q <= f_predpc_c;
      end
      if (bus.w_icode == ICODE_HALT) begin
        halted_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_select_pipe.sv
// tb/tb_pc_select_pipe.sv - randomized self-checking bench for pc_select_pipe
module tb_pc_select_pipe;
  localparam int          ADDR_W = 64;
  localparam int          DEPTH  = 2;
  localparam logic [63:0] RPC    = 64'h0;
`ifdef PC_SELECT_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall;
  logic [3:0]  f_icode, m_icode, w_icode;
  logic        m_cnd;
  logic [63:0] f_valc, f_valp, m_vala, w_valm, w_predpc;

  pc_select_pipe_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH)) bus ();

  assign bus.stall    = stall;
  assign bus.f_icode  = f_icode;
  assign bus.f_valc   = f_valc;
  assign bus.f_valp   = f_valp;
  assign bus.m_icode  = m_icode;
  assign bus.m_cnd    = m_cnd;
  assign bus.m_vala   = m_vala;
  assign bus.w_icode  = w_icode;
  assign bus.w_valm   = w_valm;
  assign bus.w_predpc = w_predpc;

  pc_select_pipe #(.ADDR_W(ADDR_W), .RESET_PC(RPC), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference state: predicted PC, sticky halt, and the return stack as a queue (back = top).
  logic [63:0] m_pred;
  bit          m_halt;
  logic [63:0] m_ras[$];
  int          err_cnt = 0;
  int          chk_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_src();
    if (m_icode == 4'd7 && !m_cnd) return 2'd1;
    if (w_icode == 4'd9 && (!RAS || w_valm != w_predpc)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [63:0] exp_pc();
    case (exp_src())
      2'd1:    return m_vala;
      2'd2:    return w_valm;
      default: return m_pred;
    endcase
  endfunction

  function automatic logic [63:0] exp_fpred();
    if (f_icode == 4'd7 || f_icode == 4'd8) return f_valc;
    if (f_icode == 4'd9 && RAS && m_ras.size() > 0) return m_ras[$];
    return f_valp;
  endfunction

  task automatic check_all();
    check("pc", bus.pc, exp_pc());
    check("pc_src", 64'(bus.pc_src), 64'(exp_src()));
    check("f_predpc", bus.f_predpc, exp_fpred());
    check("halted", 64'(bus.halted), 64'(m_halt));
    check("ras_count", 64'(bus.ras_count), RAS ? 64'(m_ras.size()) : 64'd0);
  endtask

  task automatic tick();
    logic [1:0]  src;
    logic [63:0] fp;
    src = exp_src();
    fp  = exp_fpred();
    @(posedge clk);
    if (!stall && !m_halt) begin
      if (RAS && src == 2'd0) begin
        if (f_icode == 4'd8) begin
          m_ras.push_back(f_valp);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (f_icode == 4'd9 && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
      m_pred = fp;
    end
    if (w_icode == 4'd0) m_halt = 1'b1;
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    check_all();
    tick();
  endtask

  task automatic idle();
    stall = 1'b0; f_icode = 4'd1; f_valc = '0; f_valp = '0;
    m_icode = 4'd1; m_cnd = 1'b0; m_vala = '0;
    w_icode = 4'd1; w_valm = '0; w_predpc = '0;
  endtask

  // Called in the low clock phase; outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    m_pred = RPC;
    m_halt = 1'b0;
    m_ras.delete();
    #1;
    check("rst_pc", bus.pc, RPC);
    check("rst_src", 64'(bus.pc_src), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_ras_count", 64'(bus.ras_count), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u;
    idle();
    do_reset();

    f_icode = 4'd7; f_valc = 64'h100; f_valp = 64'h20;
    step();
    idle();
    #1 check("jxx_pred_pc", bus.pc, 64'h100);

    m_icode = 4'd7; m_cnd = 1'b0; m_vala = 64'h20; f_valp = 64'h24;
    #1 check("mispredict_pc", bus.pc, 64'h20);
    check("mispredict_src", 64'(bus.pc_src), 64'd1);
    step();

    w_icode = 4'd9; w_valm = 64'h300; w_predpc = 64'h0;
    #1 check("mis_over_ret_pc", bus.pc, 64'h20);
    check("mis_over_ret_src", 64'(bus.pc_src), 64'd1);
    step();

    idle();
    stall = 1'b1; f_icode = 4'd8; f_valc = 64'h500; f_valp = 64'h28;
    repeat (3) begin
      #1 check("stall_hold_pc", bus.pc, 64'h24);
      step();
    end
    stall = 1'b0;
    step();
    idle();
    #1 check("stall_release_pc", bus.pc, 64'h500);

    f_icode = 4'd7; f_valc = 64'h40;
    step();
    idle();
    #1 check("pre_reset_pc", bus.pc, 64'h40);
    do_reset();

    w_icode = 4'd0; f_valp = 64'h60;
    step();
    idle();
    #1 check("halt_set", 64'(bus.halted), 64'd1);
    f_icode = 4'd7; f_valc = 64'h777;
    step();
    step();
    #1 check("halt_freeze_pc", bus.pc, 64'h60);
    check("halt_sticky", 64'(bus.halted), 64'd1);
    idle();
    do_reset();

    f_icode = 4'd8; f_valc = 64'h1000;
    f_valp = 64'h10; step();
    f_valp = 64'h20; step();
    f_valp = 64'h30; step();
    idle();
    f_icode = 4'd9; f_valp = 64'h90;
    if (RAS) begin
      #1 check("ras_full_count", 64'(bus.ras_count), 64'd2);
      check("ret1_pred", bus.f_predpc, 64'h30);
      step();
      #1 check("ret2_pred", bus.f_predpc, 64'h20);
      step();
      #1 check("ret_empty_pred", bus.f_predpc, 64'h90);
      check("ras_empty_count", 64'(bus.ras_count), 64'd0);
      step();
    end else begin
      #1 check("noras_ret_pred", bus.f_predpc, 64'h90);
      check("noras_count", 64'(bus.ras_count), 64'd0);
      step();
    end
    idle();
    w_icode = 4'd9; w_valm = 64'h30; w_predpc = 64'h30;
    #1 check("ret_match_src", 64'(bus.pc_src), RAS ? 64'd0 : 64'd2);
    step();

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) begin
        idle();
        do_reset();
      end
      u = $urandom_range(99);
      f_icode  = (u < 25) ? 4'd7 : (u < 50) ? 4'd8 : (u < 75) ? 4'd9 : 4'($urandom_range(15));
      f_valc   = {$urandom, $urandom};
      f_valp   = {$urandom, $urandom};
      m_icode  = ($urandom_range(99) < 15) ? 4'd7 : 4'($urandom_range(15));
      m_cnd    = 1'($urandom);
      m_vala   = {$urandom, $urandom};
      u = $urandom_range(99);
      w_icode  = (u < 15) ? 4'd9 : (u < 16) ? 4'd0 : 4'($urandom_range(15, 1));
      w_valm   = {$urandom, $urandom};
      w_predpc = $urandom_range(1) ? w_valm : {$urandom, $urandom};
      stall    = (w_icode == 4'd0) ? 1'b0 : ($urandom_range(99) < 20);
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
